v60_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that time-shares the existing 32-bit combinational ALU to run MUL/MULU (32x32->64) and DIV/DIVU (32/32 -> quotient, remainder).
- Sits beside the execute stage: accepts one request via valid/ready, drives the ALU operand/opcode inputs, consumes result/c_out, returns results plus flags via valid/ready.
- The ALU is owned by this block while busy; the execute-stage mux selects the sequencer's ALU drive whenever alu_own=1.

---
 rtl/v60_muldiv_pkg.sv | 37 +++
 rtl/v60_muldiv_seq_if.sv | 42 ++++
 rtl/v60_muldiv_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_v60_muldiv_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v60_muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encodings and the ALU opcodes it drives into the execute-stage ALU.
package v60_muldiv_pkg;

    // Request operation codes as carried on req_op.
    typedef enum logic [1:0] {
        OP_MULU = 2'd0,
        OP_MUL  = 2'd1,
        OP_DIVU = 2'd2,
        OP_DIV  = 2'd3
    } md_op_e;

    // Sequencer states, kept as plain constants for compatibility with older tools.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NEGA  = 3'd1;
    localparam logic [2:0] ST_NEGB  = 3'd2;
    localparam logic [2:0] ST_ITER  = 3'd3;
    localparam logic [2:0] ST_POST1 = 3'd4;
    localparam logic [2:0] ST_POST2 = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // ALU opcodes; the ALU decodes the same values, so they live only here.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_NEG  = 4'd13;
    localparam logic [3:0] ALU_PASS = 4'd14;

    function automatic logic is_mul_op(input md_op_e op);
        return (op == OP_MULU) || (op == OP_MUL);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/v60_muldiv_seq_if.sv
// Request/response handshake and shared-ALU drive bundle for the sequencer.
// The slave modport is the sequencer; the master modport is the execute stage.
interface v60_muldiv_seq_if #(
    parameter int DATA_W = 32
);
    import v60_muldiv_pkg::*;

    logic              req_valid;
    logic              req_ready;
    md_op_e            req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_hi;
    logic [DATA_W-1:0] resp_lo;
    logic              resp_z;
    logic              resp_s;
    logic              resp_v;
    logic              resp_dz;

    logic              alu_own;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c;

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_c,
        output req_ready, resp_valid, resp_hi, resp_lo, resp_z, resp_s, resp_v,
               resp_dz, alu_own, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_c,
        input  req_ready, resp_valid, resp_hi, resp_lo, resp_z, resp_s, resp_v,
               resp_dz, alu_own, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/v60_muldiv_seq.sv
// Iterative MUL/MULU/DIV/DIVU sequencer. It borrows the execute-stage ALU for
// one add, subtract or negate per cycle: signed operands are reduced to
// magnitudes, 32 shift-add or restoring-divide steps run, and signed results
// are negated back before being held on the response port.
module v60_muldiv_seq
    import v60_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,      // must equal the ALU width; only 32 is supported
    parameter int ITER   = DATA_W   // one quotient/product bit per iteration
) (
    input  logic            clk,
    input  logic            rst,
    v60_muldiv_seq_if.slave bus
);

    localparam int CNT_W = $clog2(ITER);

    logic [2:0]        state;
    md_op_e            op_q;
    logic [DATA_W-1:0] a_q;         // multiplicand / dividend, magnitude after NEGA
    logic [DATA_W-1:0] b_q;         // multiplier / divisor, magnitude after NEGB
    logic [DATA_W-1:0] hi;          // product high half / partial remainder
    logic [DATA_W-1:0] lo;          // product low half + multiplier / quotient + dividend
    logic [CNT_W-1:0]  cnt;
    logic              sign_q;      // result (product/quotient) must be negated
    logic              sign_r;      // remainder must be negated
    logic              lo_zero;     // low product half was zero, so the carry reaches hi
    logic              dz_q;
    logic              ovf_q;       // the one signed-divide overflow case

    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_hi_q;
    logic [DATA_W-1:0] resp_lo_q;
    logic              resp_z_q;
    logic              resp_s_q;
    logic              resp_v_q;
    logic              resp_dz_q;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;

    logic              op_mul;
    logic              op_signed;
    logic              mul_carry;
    logic              div_take;
    logic              res_v;
    logic [DATA_W-1:0] div_shift;

    assign op_mul    = is_mul_op(op_q);
    assign op_signed = is_signed_op(op_q);
    // Carry out only counts when the ALU actually added the multiplicand.
    assign mul_carry = lo[0] & bus.alu_c;
    // Remainder shifted left by one with the next dividend bit brought in.
    assign div_shift = {hi[DATA_W-2:0], lo[DATA_W-1]};
    // Subtract succeeds when the shifted-out remainder bit was set or no borrow.
    assign div_take  = hi[DATA_W-1] | ~bus.alu_c;

    // Overflow flag for the finished result, chosen by operation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        res_v = 1'b0;
        case (op_q)
            OP_MULU: res_v = (hi != '0);
            OP_MUL:  res_v = (hi != {DATA_W{lo[DATA_W-1]}});
            OP_DIV:  res_v = ovf_q;
            default: res_v = 1'b0;
        endcase
    end

    // ALU operand/opcode drive; idle drive is zero operands with PASS.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_PASS;
        case (state)
            ST_NEGA: begin
                alu_a  = a_q;
                alu_op = a_q[DATA_W-1] ? ALU_NEG : ALU_PASS;
            end
            ST_NEGB: begin
                alu_a  = b_q;
                alu_op = b_q[DATA_W-1] ? ALU_NEG : ALU_PASS;
            end
            ST_ITER: begin
                if (op_mul) begin
                    alu_a  = hi;
                    alu_b  = a_q;
                    alu_op = lo[0] ? ALU_ADD : ALU_PASS;
                end else begin
                    alu_a  = div_shift;
                    alu_b  = b_q;
                    alu_op = ALU_SUB;
                end
            end
            ST_POST1: begin
                alu_a  = lo;
                alu_op = sign_q ? ALU_NEG : ALU_PASS;
            end
            ST_POST2: begin
                alu_a = hi;
                if (op_mul)
                    alu_op = sign_q ? (lo_zero ? ALU_NEG : ALU_NOT) : ALU_PASS;
                else
                    alu_op = sign_r ? ALU_NEG : ALU_PASS;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with operand/result datapath and the registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= OP_MULU;
            a_q          <= '0;
            b_q          <= '0;
            hi           <= '0;
            lo           <= '0;
            cnt          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            lo_zero      <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo_q    <= '0;
            resp_z_q     <= 1'b0;
            resp_s_q     <= 1'b0;
            resp_v_q     <= 1'b0;
            resp_dz_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of the others.
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        hi     <= '0;
                        lo     <= is_mul_op(bus.req_op) ? bus.req_b : bus.req_a;
                        cnt    <= '0;
                        sign_q <= bus.req_a[DATA_W-1] ^ bus.req_b[DATA_W-1];
                        sign_r <= bus.req_a[DATA_W-1];
                        ovf_q  <= (bus.req_op == OP_DIV) &&
                                  (bus.req_a == {1'b1, {(DATA_W-1){1'b0}}}) &&
                                  (bus.req_b == '1);
                        dz_q   <= !is_mul_op(bus.req_op) && (bus.req_b == '0);
                        if (!is_mul_op(bus.req_op) && (bus.req_b == '0)) begin
                            lo    <= '0;
                            state <= ST_DONE;
                        end else if (is_signed_op(bus.req_op)) begin
                            state <= ST_NEGA;
                        end else begin
                            state <= ST_ITER;
                        end
                    end
                end
                ST_NEGA: begin
                    a_q   <= bus.alu_result;
                    state <= ST_NEGB;
                end
                ST_NEGB: begin
                    b_q   <= bus.alu_result;
                    lo    <= op_mul ? bus.alu_result : a_q;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (op_mul) begin
                        hi <= {mul_carry, bus.alu_result[DATA_W-1:1]};
                        lo <= {bus.alu_result[0], lo[DATA_W-1:1]};
                    end else if (div_take) begin
                        hi <= bus.alu_result;
                        lo <= {lo[DATA_W-2:0], 1'b1};
                    end else begin
                        hi <= div_shift;
                        lo <= {lo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1))
                        state <= op_signed ? ST_POST1 : ST_DONE;
                end
                ST_POST1: begin
                    lo      <= bus.alu_result;
                    lo_zero <= (lo == '0);
                    state   <= ST_POST2;
                end
                ST_POST2: begin
                    hi    <= bus.alu_result;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_hi_q    <= hi;
                        resp_lo_q    <= lo;
                        resp_z_q     <= op_mul ? ({hi, lo} == '0) : (lo == '0);
                        resp_s_q     <= op_mul ? hi[DATA_W-1] : lo[DATA_W-1];
                        resp_v_q     <= res_v;
                        resp_dz_q    <= dz_q;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hi    = resp_hi_q;
    assign bus.resp_lo    = resp_lo_q;
    assign bus.resp_z     = resp_z_q;
    assign bus.resp_s     = resp_s_q;
    assign bus.resp_v     = resp_v_q;
    assign bus.resp_dz    = resp_dz_q;
    assign bus.alu_own    = (state == ST_NEGA) || (state == ST_NEGB) || (state == ST_ITER) ||
                            (state == ST_POST1) || (state == ST_POST2);
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_op     = alu_op;

endmodule

// File: tb/tb_v60_muldiv_seq.sv
// Bench for v60_muldiv_seq: provides the shared ALU, drives directed requests,
// and compares every output each cycle against a transaction-level model
// built from 64-bit arithmetic, plus literal expectations per vector.
module tb_v60_muldiv_seq;
    import v60_muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        s;
        logic        v;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    longint cyc    = 0;

    v60_muldiv_seq_if bus ();

    v60_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle count of rising edges, used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Shared combinational ALU as the execute stage provides it.
    logic [31:0] alu_res;
    logic        alu_cout;
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (bus.alu_op)
            ALU_ADD:  {alu_cout, alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            ALU_SUB:  {alu_cout, alu_res} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            ALU_NOT:  alu_res = ~bus.alu_a;
            ALU_NEG:  {alu_cout, alu_res} = 33'd0 - {1'b0, bus.alu_a};
            ALU_PASS: alu_res = bus.alu_a;
            default:  alu_res = '0;
        endcase
    end
    assign bus.alu_result = alu_res;
    assign bus.alu_c      = alu_cout;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected response from plain 64-bit arithmetic on the request.
    function automatic exp_t model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, mp, qd, rd;
        logic [63:0] p, ua, ub, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e  = '0;
        if (op == OP_MULU || op == OP_MUL) begin
            if (op == OP_MULU) begin
                p   = ua * ub;
                e.v = (p[63:32] != 32'd0);
            end else begin
                mp  = sa * sb;
                p   = mp;
                e.v = (mp > 64'sh7FFF_FFFF) || (mp < -64'sh8000_0000);
            end
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.z   = (p == 64'd0);
            e.s   = p[63];
            e.lat = (op == OP_MUL) ? 37 : 33;
        end else if (b == 32'd0) begin
            e.dz  = 1'b1;
            e.z   = 1'b1;
            e.lat = 1;
        end else begin
            if (op == OP_DIVU) begin
                qv = ua / ub;
                rv = ua % ub;
            end else begin
                qd  = sa / sb;
                rd  = sa % sb;
                qv  = qd;
                rv  = rd;
                e.v = (qd > 64'sh7FFF_FFFF);
            end
            e.lo  = qv[31:0];
            e.hi  = rv[31:0];
            e.z   = (qv[31:0] == 32'd0);
            e.s   = qv[31];
            e.lat = (op == OP_DIV) ? 37 : 33;
        end
        return e;
    endfunction

    // Model state for the single in-flight transaction.
    exp_t   cur;
    logic   in_flight = 1'b0;
    longint acc_cyc   = 0;
    longint el;
    logic   exp_valid;
    logic   exp_own;

    // Per-cycle comparison of all outputs against the model, then model update
    // for the handshake events the coming rising edge will complete.
    always @(negedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
            check("rst_req_ready", bus.req_ready, 1);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_resp_data", {bus.resp_hi, bus.resp_lo}, 0);
            check("rst_resp_flags", {bus.resp_z, bus.resp_s, bus.resp_v, bus.resp_dz}, 0);
            check("rst_alu_own", bus.alu_own, 0);
            check("rst_alu_drive", {bus.alu_a, bus.alu_b, 28'd0, bus.alu_op}, {64'd0, 28'd0, ALU_PASS});
        end else begin
            el        = cyc - acc_cyc;
            exp_valid = in_flight && (el >= longint'(cur.lat));
            exp_own   = in_flight && !cur.dz && (el <= longint'(cur.lat - 2));
            check("req_ready", bus.req_ready, !in_flight);
            check("resp_valid", bus.resp_valid, exp_valid);
            check("alu_own", bus.alu_own, exp_own);
            if (exp_valid) begin
                check("resp_hi", bus.resp_hi, cur.hi);
                check("resp_lo", bus.resp_lo, cur.lo);
                check("resp_flags_zsvdz", {bus.resp_z, bus.resp_s, bus.resp_v, bus.resp_dz},
                      {cur.z, cur.s, cur.v, cur.dz});
            end
            if (in_flight) begin
                if (exp_valid && bus.resp_ready)
                    in_flight <= 1'b0;
            end else if (bus.req_valid) begin
                cur       <= model(bus.req_op, bus.req_a, bus.req_b);
                acc_cyc   <= cyc + 1;
                in_flight <= 1'b1;
            end
        end
    end

    // Present a request and hold it until the sequencer takes it.
    task automatic send(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout req_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait for resp_valid, capture the response, and let the handshake edge pass.
    task automatic wait_resp(output logic [31:0] hi, output logic [31:0] lo, output logic [3:0] fl);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.resp_valid) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout resp_valid stayed 0 for %0d cycles", n);
        end
        hi = bus.resp_hi;
        lo = bus.resp_lo;
        fl = {bus.resp_z, bus.resp_s, bus.resp_v, bus.resp_dz};
        if (bus.resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One directed vector with hand-computed hi, lo and {z,s,v,dz}.
    task automatic run(input string name, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic [3:0] efl);
        logic [31:0] hi, lo;
        logic [3:0]  fl;
        send(op, a, b);
        wait_resp(hi, lo, fl);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        check({name, "_flags"}, fl, efl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi, lo, hi1, lo1;
        logic [3:0]  fl, fl1;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_MULU;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run("mulu_max",   OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4'b0110);
        run("mul_m3x7",   OP_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 4'b0100);
        run("mul_0xm5",   OP_MUL,  32'd0,         32'hFFFF_FFFB, 32'd0,         32'd0,         4'b1000);
        run("mul_ovf",    OP_MUL,  32'h0001_0000, 32'h0000_8000, 32'd0,         32'h8000_0000, 4'b0010);
        run("mulu_2p32",  OP_MULU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         4'b0010);
        run("div_m7d2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0100);
        run("div_7dm2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 4'b0100);
        run("div_m8dm2",  OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd0,         32'd4,         4'b0000);
        run("divu_100d7", OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        4'b0000);
        run("divu_5d7",   OP_DIVU, 32'd5,         32'd7,         32'd5,         32'd0,         4'b1000);
        run("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 4'b0110);
        run("divu_5d0",   OP_DIVU, 32'd5,         32'd0,         32'd0,         32'd0,         4'b1001);
        run("div_0d0",    OP_DIV,  32'd0,         32'd0,         32'd0,         32'd0,         4'b1001);

        // Consumer stalls 10 cycles while a second request waits.
        bus.resp_ready = 1'b0;
        send(OP_DIVU, 32'd100, 32'd7);
        bus.req_op    = OP_MULU;
        bus.req_a     = 32'd6;
        bus.req_b     = 32'd7;
        bus.req_valid = 1'b1;
        wait_resp(hi1, lo1, fl1);
        check("stall_first_hi", hi1, 32'd2);
        check("stall_first_lo", lo1, 32'd14);
        repeat (10) begin
            @(negedge clk);
            check("stall_hold", {bus.resp_hi, bus.resp_lo}, {32'd2, 32'd14});
            check("stall_req_ready", bus.req_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        send(OP_MULU, 32'd6, 32'd7);
        wait_resp(hi, lo, fl);
        check("second_hi", hi, 32'd0);
        check("second_lo", lo, 32'd42);
        check("second_flags", fl, 4'b0000);

        // Reset in the middle of iteration 12 abandons the operation.
        send(OP_DIVU, 32'd1000, 32'd3);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_alu_own", bus.alu_own, 0);
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        run("after_rst", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 4'b0100);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
